// File: rtl/arbpri_pkg.sv
// State encoding shared by the priority stream arbiter.
package arbpri_pkg;
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;
endpackage

// File: rtl/arbpri_stream_prienc.sv
// Lowest-index-wins one-hot priority encoder with an any-valid flag.
module prienc #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic         any
);
  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    onehot = req & (~req + N'(1));
    any    = |req;
  end
endmodule

// File: rtl/arbpri_stream.sv
// Packet-locking fixed-priority N:1 stream arbiter with a registered output stage.
module arbpri_stream
  import arbpri_pkg::*;
#(
  parameter int DW = 64,
  parameter int N  = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  in_valid,
  input  logic [N-1:0]  in_last,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  output logic [N-1:0]  out_grant,
  input  logic          out_ready
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q, state_d;
  logic [LW-1:0] lk_q, lk_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [N-1:0]  out_grant_q, out_grant_d;

  logic          load;
  logic [N-1:0]  pe_oh, elig_oh, xfer_oh;
  logic          pe_any, xfer, xfer_last;
  logic [DW-1:0] xfer_data;
  logic [LW-1:0] elig_idx;

  prienc #(.N(N)) u_prienc (
    .req    (in_valid),
    .onehot (pe_oh),
    .any    (pe_any)
  );

  always_comb begin
    load    = ~out_valid_q | out_ready;
    elig_oh = '0;
    if (state_q == LOCK) begin
      elig_oh[lk_q] = 1'b1;
    end else if (pe_any) begin
      elig_oh = pe_oh;
    end
    in_ready  = (nreset && load) ? elig_oh : '0;
    xfer_oh   = in_ready & in_valid;
    xfer      = |xfer_oh;
    xfer_last = |(xfer_oh & in_last);

    xfer_data = '0;
    elig_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      xfer_data = xfer_data | (in_data[i*DW +: DW] & {DW{xfer_oh[i]}});
      if (elig_oh[i]) elig_idx = LW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    lk_d        = lk_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;

    if (xfer) begin
      case (state_q)
        IDLE: if (!xfer_last) begin
          state_d = LOCK;
          lk_d    = elig_idx;
        end
        LOCK: if (xfer_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      out_valid_d = xfer;
      out_grant_d = xfer_oh;
      if (xfer) begin
        out_data_d = xfer_data;
        out_last_d = xfer_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      lk_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
    end else begin
      state_q     <= state_d;
      lk_q        <= lk_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_grant = out_grant_q;
endmodule

// File: tb/tb_arbpri_stream.sv
// Bench for arbpri_stream: directed N=2 scenarios plus randomized N=4 run against a reference model.
module tb_arbpri_stream;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  v2 = '0, l2 = '0, r2;
  logic [15:0] d2 = '0;
  logic        ordy2 = 1'b1, ov2, ol2;
  logic [7:0]  od2;
  logic [1:0]  og2;

  logic [3:0]  v4 = '0, l4 = '0, r4;
  logic [31:0] d4 = '0;
  logic        ordy4 = 1'b1, ov4, ol4;
  logic [7:0]  od4;
  logic [3:0]  og4;

  int chk_cnt = 0;
  int pass_cnt = 0;

  arbpri_stream #(.DW(8), .N(2)) dut2 (
    .clk(clk), .nreset(nreset), .in_valid(v2), .in_last(l2), .in_data(d2),
    .in_ready(r2), .out_valid(ov2), .out_last(ol2), .out_data(od2),
    .out_grant(og2), .out_ready(ordy2)
  );

  arbpri_stream #(.DW(8), .N(4)) dut4 (
    .clk(clk), .nreset(nreset), .in_valid(v4), .in_last(l4), .in_data(d4),
    .in_ready(r4), .out_valid(ov4), .out_last(ol4), .out_data(od4),
    .out_grant(og4), .out_ready(ordy4)
  );

  typedef struct {
    logic       nr;
    logic [1:0] v, l;
    logic [7:0] d0, d1;
    logic       ordy;
    logic [1:0] rdy;
    logic       ov, ol;
    logic [7:0] od;
    logic [1:0] og;
  } cyc_t;

  function automatic cyc_t c(logic nr, logic [1:0] v, logic [1:0] l, logic [7:0] d0,
                             logic [7:0] d1, logic ordy, logic [1:0] rdy, logic ov,
                             logic ol, logic [7:0] od, logic [1:0] og);
    cyc_t x;
    x.nr = nr; x.v = v; x.l = l; x.d0 = d0; x.d1 = d1; x.ordy = ordy;
    x.rdy = rdy; x.ov = ov; x.ol = ol; x.od = od; x.og = og;
    return x;
  endfunction

  task automatic test_reset();
    cyc_t q[$];
    q.push_back(c(0, 2'b11, 2'b11, 8'h5A, 8'hA5, 1, 2'b00, 0, 0, 8'h00, 2'b00));
    q.push_back(c(0, 2'b11, 2'b00, 8'h5A, 8'hA5, 1, 2'b00, 0, 0, 8'h00, 2'b00));
    foreach (q[k]) begin
      @(negedge clk);
      nreset = q[k].nr; v2 = q[k].v; l2 = q[k].l; d2 = {q[k].d1, q[k].d0}; ordy2 = q[k].ordy;
      v4 = 4'hF;
      #1;
      chk_cnt++; if (r2 !== q[k].rdy) $display("FAIL reset_rdy[%0d]: got %b want %b", k, r2, q[k].rdy); else pass_cnt++;
      chk_cnt++; if (r4 !== 4'h0) $display("FAIL reset_rdy4[%0d]: got %b want 0000", k, r4); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({ov2, ol2, od2, og2} !== {q[k].ov, q[k].ol, q[k].od, q[k].og})
        $display("FAIL reset_out[%0d]: got v%b l%b d%h g%b want v%b l%b d%h g%b", k, ov2, ol2, od2, og2, q[k].ov, q[k].ol, q[k].od, q[k].og);
      else pass_cnt++;
      chk_cnt++; if ({ov4, ol4, od4, og4} !== 14'h0) $display("FAIL reset_out4[%0d]: got v%b l%b d%h g%b want zeros", k, ov4, ol4, od4, og4); else pass_cnt++;
    end
    v4 = '0;
  endtask

  // Table-driven directed scenario runner kept local to each test via a macro-free copy.
  task automatic test_priority();
    cyc_t q[$];
    q.push_back(c(1, 2'b11, 2'b11, 8'hA1, 8'hB2, 1, 2'b01, 1, 1, 8'hA1, 2'b01));
    q.push_back(c(1, 2'b10, 2'b11, 8'hA1, 8'hB2, 1, 2'b10, 1, 1, 8'hB2, 2'b10));
    q.push_back(c(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'hB2, 2'b00));
    foreach (q[k]) begin
      @(negedge clk);
      nreset = q[k].nr; v2 = q[k].v; l2 = q[k].l; d2 = {q[k].d1, q[k].d0}; ordy2 = q[k].ordy;
      #1;
      chk_cnt++; if (r2 !== q[k].rdy) $display("FAIL prio_rdy[%0d]: got %b want %b", k, r2, q[k].rdy); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({ov2, ol2, od2, og2} !== {q[k].ov, q[k].ol, q[k].od, q[k].og})
        $display("FAIL prio_out[%0d]: got v%b l%b d%h g%b want v%b l%b d%h g%b", k, ov2, ol2, od2, og2, q[k].ov, q[k].ol, q[k].od, q[k].og);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock();
    cyc_t q[$];
    q.push_back(c(1, 2'b10, 2'b00, 8'h00, 8'h10, 1, 2'b10, 1, 0, 8'h10, 2'b10));
    q.push_back(c(1, 2'b11, 2'b01, 8'h55, 8'h11, 1, 2'b10, 1, 0, 8'h11, 2'b10));
    q.push_back(c(1, 2'b11, 2'b11, 8'h55, 8'h12, 1, 2'b10, 1, 1, 8'h12, 2'b10));
    q.push_back(c(1, 2'b01, 2'b01, 8'h55, 8'h12, 1, 2'b01, 1, 1, 8'h55, 2'b01));
    q.push_back(c(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'h55, 2'b00));
    foreach (q[k]) begin
      @(negedge clk);
      nreset = q[k].nr; v2 = q[k].v; l2 = q[k].l; d2 = {q[k].d1, q[k].d0}; ordy2 = q[k].ordy;
      #1;
      chk_cnt++; if (r2 !== q[k].rdy) $display("FAIL lock_rdy[%0d]: got %b want %b", k, r2, q[k].rdy); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({ov2, ol2, od2, og2} !== {q[k].ov, q[k].ol, q[k].od, q[k].og})
        $display("FAIL lock_out[%0d]: got v%b l%b d%h g%b want v%b l%b d%h g%b", k, ov2, ol2, od2, og2, q[k].ov, q[k].ol, q[k].od, q[k].og);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    cyc_t q[$];
    q.push_back(c(1, 2'b01, 2'b01, 8'h21, 8'h00, 1, 2'b01, 1, 1, 8'h21, 2'b01));
    for (int i = 0; i < 4; i++)
      q.push_back(c(1, 2'b01, 2'b01, 8'h22, 8'h00, 0, 2'b00, 1, 1, 8'h21, 2'b01));
    q.push_back(c(1, 2'b01, 2'b01, 8'h22, 8'h00, 1, 2'b01, 1, 1, 8'h22, 2'b01));
    q.push_back(c(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'h22, 2'b00));
    foreach (q[k]) begin
      @(negedge clk);
      nreset = q[k].nr; v2 = q[k].v; l2 = q[k].l; d2 = {q[k].d1, q[k].d0}; ordy2 = q[k].ordy;
      #1;
      chk_cnt++; if (r2 !== q[k].rdy) $display("FAIL bp_rdy[%0d]: got %b want %b", k, r2, q[k].rdy); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({ov2, ol2, od2, og2} !== {q[k].ov, q[k].ol, q[k].od, q[k].og})
        $display("FAIL bp_out[%0d]: got v%b l%b d%h g%b want v%b l%b d%h g%b", k, ov2, ol2, od2, og2, q[k].ov, q[k].ol, q[k].od, q[k].og);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock_gap();
    cyc_t q[$];
    q.push_back(c(1, 2'b10, 2'b00, 8'h00, 8'h30, 1, 2'b10, 1, 0, 8'h30, 2'b10));
    q.push_back(c(1, 2'b01, 2'b01, 8'h40, 8'h31, 1, 2'b10, 0, 0, 8'h30, 2'b00));
    q.push_back(c(1, 2'b01, 2'b01, 8'h40, 8'h31, 1, 2'b10, 0, 0, 8'h30, 2'b00));
    q.push_back(c(1, 2'b11, 2'b11, 8'h40, 8'h31, 1, 2'b10, 1, 1, 8'h31, 2'b10));
    q.push_back(c(1, 2'b01, 2'b01, 8'h40, 8'h31, 1, 2'b01, 1, 1, 8'h40, 2'b01));
    q.push_back(c(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'h40, 2'b00));
    foreach (q[k]) begin
      @(negedge clk);
      nreset = q[k].nr; v2 = q[k].v; l2 = q[k].l; d2 = {q[k].d1, q[k].d0}; ordy2 = q[k].ordy;
      #1;
      chk_cnt++; if (r2 !== q[k].rdy) $display("FAIL gap_rdy[%0d]: got %b want %b", k, r2, q[k].rdy); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({ov2, ol2, od2, og2} !== {q[k].ov, q[k].ol, q[k].od, q[k].og})
        $display("FAIL gap_out[%0d]: got v%b l%b d%h g%b want v%b l%b d%h g%b", k, ov2, ol2, od2, og2, q[k].ov, q[k].ol, q[k].od, q[k].og);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_in_lock();
    cyc_t q[$];
    q.push_back(c(1, 2'b10, 2'b00, 8'h00, 8'h50, 1, 2'b10, 1, 0, 8'h50, 2'b10));
    q.push_back(c(0, 2'b11, 2'b01, 8'h60, 8'h51, 1, 2'b00, 0, 0, 8'h00, 2'b00));
    q.push_back(c(1, 2'b11, 2'b01, 8'h60, 8'h51, 1, 2'b01, 1, 1, 8'h60, 2'b01));
    q.push_back(c(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'h60, 2'b00));
    foreach (q[k]) begin
      @(negedge clk);
      nreset = q[k].nr; v2 = q[k].v; l2 = q[k].l; d2 = {q[k].d1, q[k].d0}; ordy2 = q[k].ordy;
      #1;
      chk_cnt++; if (r2 !== q[k].rdy) $display("FAIL rstlock_rdy[%0d]: got %b want %b", k, r2, q[k].rdy); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({ov2, ol2, od2, og2} !== {q[k].ov, q[k].ol, q[k].od, q[k].og})
        $display("FAIL rstlock_out[%0d]: got v%b l%b d%h g%b want v%b l%b d%h g%b", k, ov2, ol2, od2, og2, q[k].ov, q[k].ol, q[k].od, q[k].og);
      else pass_cnt++;
    end
  endtask

  // Reference model: an owner index for the open packet, the expected output register contents,
  // and per-source sequence counters embedded in the data byte ({src, seq[5:0]}).
  task automatic test_random();
    int owner = -1;
    logic m_ov = 1'b0, m_ol = 1'b0;
    logic [7:0] m_od = '0;
    logic [3:0] m_og = '0;
    bit pend[4];
    logic [7:0] pdat[4];
    bit plast[4];
    int seq[4], rem[4], nxt_out[4];
    int prev_src = -1;
    bit prev_last = 1'b1;
    int win, src;
    bit load, xfer;
    logic [3:0] exp_rdy;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0; pdat[i] = '0; plast[i] = 0; seq[i] = 0; rem[i] = 0; nxt_out[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          if (rem[i] == 0) rem[i] = $urandom_range(4, 1);
          pdat[i] = {i[1:0], seq[i][5:0]};
          plast[i] = (rem[i] == 1);
          pend[i] = 1;
        end
        v4[i] = pend[i] && ($urandom_range(3, 0) != 0);
        l4[i] = plast[i];
        d4[i*8 +: 8] = pdat[i];
      end
      ordy4 = ($urandom_range(9, 0) < 7);
      #1;
      load = !m_ov || ordy4;
      win = owner;
      if (owner < 0)
        for (int i = 3; i >= 0; i--) if (v4[i]) win = i;
      exp_rdy = (load && win >= 0) ? 4'(1 << win) : 4'h0;
      xfer = (win >= 0) && load && v4[win];
      chk_cnt++; if (r4 !== exp_rdy) $display("FAIL rnd_rdy cyc %0d: got %b want %b", cyc, r4, exp_rdy); else pass_cnt++;
      chk_cnt++; if ($countones(r4) > 1) $display("FAIL rnd_onehot cyc %0d: got %b want at most one bit", cyc, r4); else pass_cnt++;
      if (ov4 && ordy4) begin
        src = 0;
        for (int i = 0; i < 4; i++) if (og4[i]) src = i;
        chk_cnt++;
        if (!$onehot(og4) || od4[7:6] !== src[1:0] || od4[5:0] !== nxt_out[src][5:0])
          $display("FAIL rnd_order cyc %0d: got g%b d%h want src%0d seq%0d", cyc, og4, od4, src, nxt_out[src] % 64);
        else pass_cnt++;
        nxt_out[src]++;
        chk_cnt++;
        if (!prev_last && src != prev_src) $display("FAIL rnd_interleave cyc %0d: got src %0d want src %0d", cyc, src, prev_src);
        else pass_cnt++;
        prev_src = src;
        prev_last = ol4;
      end
      if (load) begin
        if (xfer) begin
          m_ov = 1'b1; m_od = pdat[win]; m_ol = plast[win]; m_og = 4'(1 << win);
          owner = plast[win] ? -1 : win;
          pend[win] = 0; seq[win]++; rem[win]--;
        end else begin
          m_ov = 1'b0; m_og = '0;
        end
      end
      @(posedge clk); #1;
      chk_cnt++;
      if ({ov4, ol4, od4, og4} !== {m_ov, m_ol, m_od, m_og})
        $display("FAIL rnd_out cyc %0d: got v%b l%b d%h g%b want v%b l%b d%h g%b", cyc, ov4, ol4, od4, og4, m_ov, m_ol, m_od, m_og);
      else pass_cnt++;
    end
    @(negedge clk);
    v4 = '0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_backpressure();
    test_lock_gap();
    test_reset_in_lock();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
